// File: rtl/instr_enc.sv
// Op-word to 4-bit opcode encoder feeding a small FIFO; illegal words are dropped and counted.
// Optional INSTR_ENC_PARITY_EN stores a parity bit per entry and exposes opcode_par.
module instr_enc #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             op_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              opcode,
    output logic                    illegal,
    output logic [7:0]              illegal_cnt,
    output logic [$clog2(DEPTH):0]  level
`ifdef INSTR_ENC_PARITY_EN
    ,
    output logic                    opcode_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef INSTR_ENC_PARITY_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] din;
    logic [EW-1:0] hd;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          legal;
    logic          acc;
    logic          push;
    logic          drop;
    logic          pop;
    logic          full;

    assign full      = (level == LW'(DEPTH));
    assign in_ready  = !reset && enable && !full;
    assign out_valid = (level != '0);
    assign legal     = (op_word[15:4] == 12'd0);
    assign acc       = in_valid && in_ready;
    assign push      = acc && legal;
    assign drop      = acc && !legal;
    assign pop       = out_valid && out_ready;
    assign hd        = mem[head];
    assign opcode    = out_valid ? hd[3:0] : 4'h0;

`ifdef INSTR_ENC_PARITY_EN
    assign din        = {^op_word[3:0], op_word[3:0]};
    assign opcode_par = out_valid ? hd[4] : 1'b0;
`else
    assign din        = op_word[3:0];
`endif

    // Storage needs no reset: out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            level       <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            illegal <= drop;
            if (drop && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_enc;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic        illegal;
    logic [7:0]  illegal_cnt;
    logic [2:0]  level;
`ifdef INSTR_ENC_PARITY_EN
    logic        opcode_par;
`endif

    instr_enc #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_word(op_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .opcode(opcode),
        .illegal(illegal),
        .illegal_cnt(illegal_cnt),
        .level(level)
`ifdef INSTR_ENC_PARITY_EN
        ,
        .opcode_par(opcode_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q[$];
    int m_cnt;
    int m_ill;

    typedef struct {
        bit        r;
        bit        e;
        bit        v;
        bit [15:0] w;
        bit        o;
        int        lvl;
        int        ov;
        int        opc;
        int        ill;
        int        cnt;
        int        rdy;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_rdy();
        return (!reset && enable && m_q.size() < DEPTH) ? 1 : 0;
    endfunction

    // Drive inputs, advance the model across the edge, then wait past the edge.
    task automatic step(input bit r, input bit e, input bit v,
                        input bit [15:0] w, input bit o);
        int acc;
        reset = r;
        enable = e;
        in_valid = v;
        op_word = w;
        out_ready = o;
        if (r) begin
            m_q.delete();
            m_cnt = 0;
            m_ill = 0;
        end else begin
            acc = (v && m_rdy()) ? 1 : 0;
            if (m_q.size() > 0 && o) void'(m_q.pop_front());
            m_ill = (acc && w[15:4] != 0) ? 1 : 0;
            if (m_ill && m_cnt < 255) m_cnt++;
            if (acc && w[15:4] == 0) m_q.push_back(int'(w[3:0]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        int eop;
        eop = (m_q.size() > 0) ? m_q[0] : 0;
        chk({tag, "_level"}, int'(level), m_q.size());
        chk({tag, "_out_valid"}, int'(out_valid), (m_q.size() > 0) ? 1 : 0);
        chk({tag, "_opcode"}, int'(opcode), eop);
        chk({tag, "_illegal"}, int'(illegal), m_ill);
        chk({tag, "_cnt"}, int'(illegal_cnt), m_cnt);
        chk({tag, "_in_ready"}, int'(in_ready), m_rdy());
`ifdef INSTR_ENC_PARITY_EN
        chk({tag, "_par"}, int'(opcode_par), ^eop[3:0]);
`endif
    endtask

    function automatic vec_t mk(bit r, bit e, bit v, bit [15:0] w, bit o,
                                int lvl, int ov, int opc, int ill, int cnt, int rdy);
        vec_t x;
        x.r = r; x.e = e; x.v = v; x.w = w; x.o = o;
        x.lvl = lvl; x.ov = ov; x.opc = opc; x.ill = ill; x.cnt = cnt; x.rdy = rdy;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        in_valid = 1'b0;
        op_word = 16'h0;
        out_ready = 1'b0;
        m_cnt = 0;
        m_ill = 0;

        //           r  e  v  word      o  lvl ov opc ill cnt rdy
        vt.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0005, 0, 1, 1, 5, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0001, 0, 1, 1, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0002, 0, 2, 1, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0003, 0, 3, 1, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0007, 0, 4, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0009, 0, 4, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 3, 1, 2, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 2, 1, 3, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 1, 7, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 16'h0010, 0, 0, 0, 0, 1, 1, 1));
        vt.push_back(mk(0, 1, 1, 16'h8003, 0, 0, 0, 0, 1, 2, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0001, 0, 1, 1, 1, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0002, 0, 2, 1, 1, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h000A, 1, 2, 1, 2, 0, 2, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 1, 10, 0, 2, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0003, 0, 1, 1, 3, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0004, 0, 2, 1, 3, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0005, 0, 3, 1, 3, 0, 2, 1));
        vt.push_back(mk(0, 0, 1, 16'h0006, 0, 3, 1, 3, 0, 2, 0));
        vt.push_back(mk(0, 0, 1, 16'h0006, 1, 2, 1, 4, 0, 2, 0));
        vt.push_back(mk(0, 0, 1, 16'h0006, 1, 1, 1, 5, 0, 2, 0));
        vt.push_back(mk(0, 0, 1, 16'h0006, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(0, 1, 1, 16'h0008, 0, 1, 1, 8, 0, 2, 1));
        vt.push_back(mk(0, 1, 1, 16'h0100, 1, 0, 0, 0, 1, 3, 1));
        vt.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1));

        foreach (vt[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vt[i].r, vt[i].e, vt[i].v, vt[i].w, vt[i].o);
            chk({t, "_level"}, int'(level), vt[i].lvl);
            chk({t, "_out_valid"}, int'(out_valid), vt[i].ov);
            chk({t, "_opcode"}, int'(opcode), vt[i].opc);
            chk({t, "_illegal"}, int'(illegal), vt[i].ill);
            chk({t, "_cnt"}, int'(illegal_cnt), vt[i].cnt);
            chk({t, "_in_ready"}, int'(in_ready), vt[i].rdy);
`ifdef INSTR_ENC_PARITY_EN
            begin
                bit [3:0] eo;
                eo = vt[i].opc[3:0];
                chk({t, "_par"}, int'(opcode_par), int'(^eo));
            end
`endif
        end

        // Saturation: 260 back-to-back illegal words on top of the 3 already counted
        for (int i = 0; i < 260; i++) begin
            step(0, 1, 1, 16'hF000 | 16'(i), 0);
            if (i == 0) chk("sat_first_illegal", int'(illegal), 1);
            if (i == 100) chk("sat_mid_cnt", int'(illegal_cnt), 104);
        end
        chk("sat_cnt", int'(illegal_cnt), 255);
        chk("sat_level", int'(level), 0);
        step(0, 1, 0, 16'h0, 0);
        chk("sat_illegal_off", int'(illegal), 0);
        chk("sat_hold", int'(illegal_cnt), 255);

        // Reset mid-operation with level 3 and count 9
        step(1, 1, 0, 16'h0, 0);
        chk("rst_cnt_clear", int'(illegal_cnt), 0);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 16'h0020, 0);
        step(0, 1, 1, 16'h000C, 0);
        step(0, 1, 1, 16'h000D, 0);
        step(0, 1, 1, 16'h000E, 0);
        chk("pre_rst_level", int'(level), 3);
        chk("pre_rst_cnt", int'(illegal_cnt), 9);
        step(1, 1, 0, 16'h0, 1);
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_cnt", int'(illegal_cnt), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        step(0, 1, 0, 16'h0, 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_opcode", int'(opcode), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit [15:0] w;
            r = ($urandom_range(63) == 0);
            if ($urandom_range(3) != 0) w = 16'($urandom_range(15));
            else w = 16'($urandom_range(16'hFFFF, 16'h0010));
            step(r, $urandom_range(7) != 0, $urandom_range(1) == 1, w,
                 $urandom_range(2) != 0);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
